// File: rtl/neuron_lanes.sv
// neuron_lanes: one neuron of a layer. Each beat carries LANES signed Q(FRAC_BITS)
// inputs. The block multiplies them by weights held in an internal bank, adds the
// products into a saturating accumulator, adds a bias and applies an activation
// (ReLU or saturating identity). Input and output both use valid/ready handshakes,
// and the block re-arms for the next vector after each result is taken.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   S_IDLE   | waiting for the first beat; weight and bias writes are accepted
//   S_ACCUM  | taking beats 1..BEATS-1; in_valid low simply stalls
//   S_DRAIN  | letting the last beat pass the multiply/accumulate stages
//   S_OUTPUT | result is presented and held until out_ready
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       input beat handshake; in_data lane i = [i*DATA_W +: DATA_W]
//   wt_we/wt_addr/wt_data   weight write (index = beat*LANES + lane), honoured only in S_IDLE
//   bias_we/bias_data       bias write, honoured only in S_IDLE
//   out_valid/out_ready     result handshake; out_data is held while out_valid is high
//   busy                    high in any state other than S_IDLE
module neuron_lanes #(
    parameter int DATA_W      = 8,
    parameter int FRAC_BITS   = 4,
    parameter int NUM_WEIGHTS = 256,
    parameter int LANES       = 4,
    parameter int ACC_W       = 24,
    parameter int ACT_MODE    = 0,
    localparam int AW         = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      wt_we,
    input  logic [AW-1:0]             wt_addr,
    input  logic [DATA_W-1:0]         wt_data,
    input  logic                      bias_we,
    input  logic [DATA_W-1:0]         bias_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      busy
);

    localparam int BEATS  = NUM_WEIGHTS / LANES;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int PSUM_W = 2 * DATA_W + $clog2(LANES);

    localparam logic signed [ACC_W-1:0] C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] C_DAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] C_DAT_MIN = -C_DAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t                    r_state;
    logic [BW-1:0]             r_beat_cnt;
    logic [1:0]                r_drain_cnt;
    logic signed [DATA_W-1:0]  r_wt_mem [NUM_WEIGHTS];
    logic signed [DATA_W-1:0]  r_bias;
    logic signed [DATA_W-1:0]  r_s1_x  [LANES];
    logic signed [DATA_W-1:0]  r_s1_wt [LANES];
    logic                      r_s1_valid;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;

    logic                      w_accept;
    logic signed [PROD_W-1:0]  w_prod [LANES];
    logic signed [PSUM_W-1:0]  w_psum;
    logic signed [ACC_W:0]     w_acc_sum;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W:0]     w_bias_sh;
    logic signed [ACC_W:0]     w_out_sum;
    logic signed [ACC_W-1:0]   w_out_sat;
    logic signed [ACC_W-1:0]   w_res;
    logic [DATA_W-1:0]         w_res_sat;
    logic [DATA_W-1:0]         w_act;

    assign in_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign w_accept  = in_valid && in_ready;

    // S2: lane products summed, then saturating add into the accumulator.
    // Overflow shows up as the two top bits of the one-bit-wider sum disagreeing.
    always_comb begin
        w_psum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_prod[l] = r_s1_x[l] * r_s1_wt[l];
            w_psum    = w_psum + PSUM_W'(w_prod[l]);
        end
        w_acc_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_psum);
        if (w_acc_sum[ACC_W] != w_acc_sum[ACC_W-1])
            w_acc_next = w_acc_sum[ACC_W] ? C_ACC_MIN : C_ACC_MAX;
        else
            w_acc_next = w_acc_sum[ACC_W-1:0];
    end

    // S3: bias is aligned to the accumulator's 2*FRAC_BITS binary point, the sum
    // is saturated, shifted back to FRAC_BITS and clipped to the output range.
    always_comb begin
        w_bias_sh = (ACC_W+1)'(r_bias) <<< FRAC_BITS;
        w_out_sum = (ACC_W+1)'(r_acc) + w_bias_sh;
        if (w_out_sum[ACC_W] != w_out_sum[ACC_W-1])
            w_out_sat = w_out_sum[ACC_W] ? C_ACC_MIN : C_ACC_MAX;
        else
            w_out_sat = w_out_sum[ACC_W-1:0];
        w_res = w_out_sat >>> FRAC_BITS;
        if (w_res > C_DAT_MAX)
            w_res_sat = C_DAT_MAX[DATA_W-1:0];
        else if (w_res < C_DAT_MIN)
            w_res_sat = C_DAT_MIN[DATA_W-1:0];
        else
            w_res_sat = w_res[DATA_W-1:0];
        if ((ACT_MODE == 0) && w_res_sat[DATA_W-1])
            w_act = '0;
        else
            w_act = w_res_sat;
    end

    // Weight bank and bias are storage only and keep their contents across reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            if (wt_we)
                r_wt_mem[wt_addr] <= wt_data;
            if (bias_we)
                r_bias <= bias_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_s1_valid  <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_s1_x[l]  <= '0;
                r_s1_wt[l] <= '0;
            end
        end else begin
            // S1: weight read at the beat address, registered with the beat data
            r_s1_valid <= w_accept;
            if (w_accept) begin
                for (int l = 0; l < LANES; l++) begin
                    r_s1_x[l]  <= in_data[l*DATA_W +: DATA_W];
                    r_s1_wt[l] <= r_wt_mem[AW'(int'(r_beat_cnt) * LANES + l)];
                end
            end

            if (r_s1_valid)
                r_acc <= w_acc_next;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc       <= '0;
                        r_drain_cnt <= '0;
                        if (BEATS == 1) begin
                            r_beat_cnt <= '0;
                            r_state    <= S_DRAIN;
                        end else begin
                            r_beat_cnt <= BW'(1);
                            r_state    <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (r_beat_cnt == BW'(BEATS - 1)) begin
                            r_beat_cnt  <= '0;
                            r_drain_cnt <= '0;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // The last product lands in r_acc on the first drain edge; the
                    // result is registered on the third so out_valid rises three
                    // edges after the last beat was taken.
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                    if (r_drain_cnt == 2'd2) begin
                        r_out_data  <= w_act;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_lanes.sv
// Bench for neuron_lanes with DATA_W=8, FRAC_BITS=4, LANES=4, NUM_WEIGHTS=8 (two beats
// per vector). A ReLU instance and an identity instance share every input; the
// expected results come from an integer model of the neuron's arithmetic.
module tb_neuron_lanes;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        wt_we;
    logic [2:0]  wt_addr;
    logic [7:0]  wt_data;
    logic        bias_we;
    logic [7:0]  bias_data;
    logic        out_ready;

    logic        rl_in_ready, rl_out_valid, rl_busy;
    logic [7:0]  rl_out_data;
    logic        id_in_ready, id_out_valid, id_busy;
    logic [7:0]  id_out_data;

    int total = 0;
    int bad   = 0;

    int m_w [8];
    int m_x [8];
    int m_bias;
    int busy_wt_val;
    int busy_bias_val;

    always #5 clk = ~clk;

    neuron_lanes #(.DATA_W(8), .FRAC_BITS(4), .NUM_WEIGHTS(8), .LANES(4),
                   .ACC_W(24), .ACT_MODE(0)) dut_relu (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rl_in_ready),
        .in_data(in_data), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_we(bias_we), .bias_data(bias_data), .out_valid(rl_out_valid),
        .out_ready(out_ready), .out_data(rl_out_data), .busy(rl_busy));

    neuron_lanes #(.DATA_W(8), .FRAC_BITS(4), .NUM_WEIGHTS(8), .LANES(4),
                   .ACC_W(24), .ACT_MODE(1)) dut_ident (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(id_in_ready),
        .in_data(in_data), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_we(bias_we), .bias_data(bias_data), .out_valid(id_out_valid),
        .out_ready(out_ready), .out_data(id_out_data), .busy(id_busy));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Neuron arithmetic on plain integers: products in Q8, 24-bit saturating
    // accumulation per beat, bias shifted up to Q8, floor back to Q4, clip to 8 bits.
    function automatic int model(input bit relu);
        longint acc = 0;
        longint s;
        longint r;
        for (int b = 0; b < 2; b++) begin
            s = 0;
            for (int l = 0; l < 4; l++)
                s += longint'(m_w[b*4+l]) * longint'(m_x[b*4+l]);
            acc = clamp(acc + s, -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
        end
        acc = clamp(acc + longint'(m_bias) * 16, -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
        r = clamp(acc >>> 4, -128, 127);
        if (relu && r < 0) r = 0;
        return int'(r);
    endfunction

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_params();
        for (int i = 0; i < 8; i++) begin
            wt_we   = 1'b1;
            wt_addr = 3'(i);
            wt_data = 8'(m_w[i]);
            tick();
        end
        wt_we     = 1'b0;
        bias_we   = 1'b1;
        bias_data = 8'(m_bias);
        tick();
        bias_we   = 1'b0;
    endtask

    task automatic send_beat(input int b);
        in_valid = 1'b1;
        for (int l = 0; l < 4; l++)
            in_data[l*8 +: 8] = 8'(m_x[b*4+l]);
        chk("in_ready_beat", int'(rl_in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int gap, input int hold, input bit wr_busy);
        int exp_r;
        int exp_i;
        int held;
        exp_r = model(1'b1);
        exp_i = model(1'b0);
        for (int b = 0; b < 2; b++) begin
            repeat (gap) tick();
            send_beat(b);
            if (b == 0 && wr_busy) begin
                wt_we     = 1'b1;
                wt_addr   = 3'd0;
                wt_data   = 8'(busy_wt_val);
                bias_we   = 1'b1;
                bias_data = 8'(busy_bias_val);
                tick();
                wt_we     = 1'b0;
                bias_we   = 1'b0;
            end
        end
        chk("busy_drain", int'(rl_busy), 1);
        // junk offered while draining/outputting must be ignored
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("out_valid_c%0d", c), int'(rl_out_valid), (c == 3) ? 1 : 0);
        end
        chk("id_out_valid", int'(id_out_valid), 1);
        chk("in_ready_out", int'(rl_in_ready), 0);
        chk("relu_data", s8(rl_out_data), exp_r);
        chk("ident_data", s8(id_out_data), exp_i);
        held = s8(id_out_data);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("held_valid", int'(id_out_valid), 1);
            chk("held_data", s8(id_out_data), held);
            chk("held_ready", int'(id_in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("valid_cleared", int'(rl_out_valid), 0);
        chk("idle_busy", int'(id_busy), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        wt_we     = 1'b0;
        wt_addr   = '0;
        wt_data   = '0;
        bias_we   = 1'b0;
        bias_data = '0;
        out_ready = 1'b0;
        busy_wt_val   = 0;
        busy_bias_val = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        chk("rst_busy", int'(rl_busy), 0);
        chk("rst_valid", int'(rl_out_valid), 0);
        chk("rst_data", int'(id_out_data), 0);
        chk("rst_ready", int'(id_in_ready), 1);

        // all ones: 8.0 saturates to 127
        for (int i = 0; i < 8; i++) begin m_w[i] = 16; m_x[i] = 16; end
        m_bias = 0;
        load_params();
        run_vec(0, 0, 1'b0);

        // 2.0 + 0.5 bias
        m_x = '{16, 0, 0, 0, 16, 0, 0, 0};
        m_bias = 8;
        load_params();
        run_vec(0, 0, 1'b0);

        // negative: -2.0 - 0.5 -> -40 identity, 0 ReLU
        m_x = '{-16, 0, 0, 0, -16, 0, 0, 0};
        m_bias = -8;
        load_params();
        run_vec(0, 0, 1'b0);

        // input gaps and a held result
        m_x = '{16, 8, 0, -4, 16, 0, 2, 0};
        m_bias = 8;
        load_params();
        run_vec(5, 4, 1'b0);

        // back-to-back vectors, accumulator must start fresh
        m_x = '{32, 32, 32, 32, 0, 0, 0, 0};
        run_vec(0, 0, 1'b0);
        m_x = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_vec(0, 0, 1'b0);

        // reset during accumulation aborts the vector
        send_beat(0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", int'(rl_busy), 0);
        chk("midrst_valid", int'(id_out_valid), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) tick();
        chk("postrst_valid", int'(rl_out_valid), 0);
        m_x = '{16, 0, 16, 0, 0, 16, 0, 16};
        run_vec(0, 0, 1'b0);

        // writes while busy are dropped; the same write in idle takes effect
        for (int i = 0; i < 8; i++) m_w[i] = 16;
        m_x = '{16, 0, 0, 0, 0, 0, 0, 0};
        m_bias = 0;
        load_params();
        busy_wt_val   = -16;
        busy_bias_val = 40;
        run_vec(0, 0, 1'b1);
        m_w[0] = -16;
        load_params();
        run_vec(0, 0, 1'b0);

        // randomized vectors
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) m_w[i] = int'($urandom_range(0, 255)) - 128;
                m_bias = int'($urandom_range(0, 255)) - 128;
                load_params();
            end
            for (int i = 0; i < 8; i++)
                m_x[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128
                                                     : int'($urandom_range(0, 64)) - 32;
            busy_wt_val   = int'($urandom_range(0, 255)) - 128;
            busy_bias_val = int'($urandom_range(0, 255)) - 128;
            run_vec(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
